// File: rtl/fb_bank_arbiter.sv
// rtl/fb_bank_arbiter.sv - double-buffered framebuffer arbiter: display reads, clear engine, pixel writer
// Display reads the front bank; clear engine and writer fill the back bank; swaps land on frame_end.
module fb_bank_arbiter #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 12,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              disp_rd_req,
  input  logic [ADDR_W-1:0] disp_rd_addr,
  output logic [DATA_W-1:0] disp_rd_data,
  output logic              disp_rd_valid,
  input  logic              wr_valid,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic              swap_req,
  input  logic              frame_end,
  input  logic              clear_req,
  output logic              swap_pending,
  output logic              clearing,
  output logic              clear_done,
  output logic              front_bank,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W:0]   mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  clr_state_t        state;
  clr_state_t        state_next;
  logic [ADDR_W-1:0] clear_addr;
  logic [ADDR_W-1:0] clear_addr_next;
  logic              clear_done_next;

  logic disp_grant;
  logic clear_grant;
  logic wr_grant;

  assign clearing = (state == CLEAR);

  // Every grant is gated by rst so nothing touches the RAM while in reset.
  assign disp_grant  = !rst && disp_rd_req;
  assign clear_grant = !rst && clearing && !disp_rd_req;
  assign wr_ready    = !rst && !disp_rd_req && !clearing && !swap_pending;
  assign wr_grant    = wr_valid && wr_ready;

  assign disp_rd_data = mem_rdata;

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (disp_grant) begin
      mem_en   = 1'b1;
      mem_addr = {front_bank, disp_rd_addr};
    end else if (clear_grant) begin
      mem_en    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = {~front_bank, clear_addr};
      mem_wdata = CLEAR_VAL;
    end else if (wr_grant) begin
      mem_en    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = {~front_bank, wr_addr};
      mem_wdata = wr_data;
    end
  end

  always_comb begin
    state_next      = state;
    clear_addr_next = clear_addr;
    clear_done_next = 1'b0;
    case (state)
      IDLE: begin
        if (clear_req && !swap_pending) begin
          state_next      = CLEAR;
          clear_addr_next = '0;
        end
      end
      CLEAR: begin
        if (clear_grant) begin
          clear_addr_next = clear_addr + 1'b1;
          if (clear_addr == LAST_ADDR) begin
            state_next      = IDLE;
            clear_done_next = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      clear_addr    <= '0;
      clear_done    <= 1'b0;
      disp_rd_valid <= 1'b0;
    end else begin
      state         <= state_next;
      clear_addr    <= clear_addr_next;
      clear_done    <= clear_done_next;
      disp_rd_valid <= disp_grant;
    end
  end

  // Arming wins over a same-cycle frame_end; a swap never lands while the back bank is being cleared.
  always_ff @(posedge clk) begin
    if (rst) begin
      front_bank   <= 1'b0;
      swap_pending <= 1'b0;
    end else if (swap_req && !swap_pending) begin
      swap_pending <= 1'b1;
    end else if (swap_pending && frame_end && !clearing) begin
      front_bank   <= ~front_bank;
      swap_pending <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fb_bank_arbiter.sv
// tb/tb_fb_bank_arbiter.sv - directed self-checking bench for fb_bank_arbiter
// A 4096-word RAM model sits on the mem_* port; it can be preset to addr ^ 0x5A5.
module tb_fb_bank_arbiter;

  logic        clk;
  logic        rst;
  logic        disp_rd_req;
  logic [10:0] disp_rd_addr;
  logic [11:0] disp_rd_data;
  logic        disp_rd_valid;
  logic        wr_valid;
  logic [10:0] wr_addr;
  logic [11:0] wr_data;
  logic        wr_ready;
  logic        swap_req;
  logic        frame_end;
  logic        clear_req;
  logic        swap_pending;
  logic        clearing;
  logic        clear_done;
  logic        front_bank;
  logic        mem_en;
  logic        mem_we;
  logic [11:0] mem_addr;
  logic [11:0] mem_wdata;
  logic [11:0] mem_rdata;

  logic [11:0] ram  [0:4095];
  int          wcnt [0:4095];
  logic        ram_init;
  logic        track;
  logic        track2;
  int          post_writes;
  int          n_cmp;
  int          n_bad;

  fb_bank_arbiter #(.ADDR_W(11), .DATA_W(12), .CLEAR_VAL(12'h000)) dut (
    .clk(clk), .rst(rst),
    .disp_rd_req(disp_rd_req), .disp_rd_addr(disp_rd_addr),
    .disp_rd_data(disp_rd_data), .disp_rd_valid(disp_rd_valid),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .swap_req(swap_req), .frame_end(frame_end), .clear_req(clear_req),
    .swap_pending(swap_pending), .clearing(clearing), .clear_done(clear_done),
    .front_bank(front_bank),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_init) begin
      for (int k = 0; k < 4096; k++) begin
        ram[k]  <= 12'(k) ^ 12'h5A5;
        wcnt[k] <= 0;
      end
      mem_rdata   <= '0;
      post_writes <= 0;
    end else begin
      if (mem_en && mem_we) begin
        ram[mem_addr] <= mem_wdata;
        if (track) wcnt[mem_addr] <= wcnt[mem_addr] + 1;
        if (track2) post_writes <= post_writes + 1;
      end
      if (mem_en && !mem_we) mem_rdata <= ram[mem_addr];
    end
  end

  task automatic test_reset;
    rst = 1'b1; ram_init = 1'b1; wr_valid = 1'b1; disp_rd_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    n_cmp++; if (wr_ready !== 1'b0) begin n_bad++; $display("FAIL rst_wr_ready: got %b want 0", wr_ready); end
    n_cmp++; if (mem_en !== 1'b0) begin n_bad++; $display("FAIL rst_mem_en: got %b want 0", mem_en); end
    ram_init = 1'b0;
    @(negedge clk);
    rst = 1'b0; wr_valid = 1'b0; disp_rd_req = 1'b0;
    #1;
    n_cmp++; if (front_bank !== 1'b0) begin n_bad++; $display("FAIL rst_front_bank: got %b want 0", front_bank); end
    n_cmp++; if (swap_pending !== 1'b0) begin n_bad++; $display("FAIL rst_swap_pending: got %b want 0", swap_pending); end
    n_cmp++; if (clearing !== 1'b0) begin n_bad++; $display("FAIL rst_clearing: got %b want 0", clearing); end
    n_cmp++; if (clear_done !== 1'b0) begin n_bad++; $display("FAIL rst_clear_done: got %b want 0", clear_done); end
    n_cmp++; if (disp_rd_valid !== 1'b0) begin n_bad++; $display("FAIL rst_rd_valid: got %b want 0", disp_rd_valid); end
  endtask

  task automatic test_read;
    @(negedge clk);
    disp_rd_req = 1'b1; disp_rd_addr = 11'd5;
    #1;
    n_cmp++; if (mem_en !== 1'b1) begin n_bad++; $display("FAIL rd_mem_en: got %b want 1", mem_en); end
    n_cmp++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL rd_mem_we: got %b want 0", mem_we); end
    n_cmp++; if (mem_addr !== 12'h005) begin n_bad++; $display("FAIL rd_mem_addr: got %h want 005", mem_addr); end
    @(negedge clk);
    disp_rd_req = 1'b0;
    #1;
    n_cmp++; if (disp_rd_valid !== 1'b1) begin n_bad++; $display("FAIL rd_valid: got %b want 1", disp_rd_valid); end
    n_cmp++; if (disp_rd_data !== 12'h5A0) begin n_bad++; $display("FAIL rd_data: got %h want 5a0", disp_rd_data); end
    @(negedge clk);
    #1;
    n_cmp++; if (disp_rd_valid !== 1'b0) begin n_bad++; $display("FAIL rd_valid_drop: got %b want 0", disp_rd_valid); end
  endtask

  task automatic test_arbitration;
    @(negedge clk);
    disp_rd_req = 1'b1; disp_rd_addr = 11'd0;
    wr_valid = 1'b1; wr_addr = 11'd7; wr_data = 12'hABC;
    #1;
    n_cmp++; if (wr_ready !== 1'b0) begin n_bad++; $display("FAIL arb_wr_ready_blocked: got %b want 0", wr_ready); end
    n_cmp++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL arb_mem_we_read: got %b want 0", mem_we); end
    @(negedge clk);
    disp_rd_req = 1'b0;
    #1;
    n_cmp++; if (wr_ready !== 1'b1) begin n_bad++; $display("FAIL arb_wr_ready: got %b want 1", wr_ready); end
    n_cmp++; if (mem_we !== 1'b1) begin n_bad++; $display("FAIL arb_mem_we: got %b want 1", mem_we); end
    n_cmp++; if (mem_addr !== 12'h807) begin n_bad++; $display("FAIL arb_mem_addr: got %h want 807", mem_addr); end
    n_cmp++; if (mem_wdata !== 12'hABC) begin n_bad++; $display("FAIL arb_mem_wdata: got %h want abc", mem_wdata); end
    @(negedge clk);
    wr_valid = 1'b0;
    #1;
    n_cmp++; if (ram[12'h807] !== 12'hABC) begin n_bad++; $display("FAIL arb_ram_807: got %h want abc", ram[12'h807]); end
    n_cmp++; if (mem_en !== 1'b0) begin n_bad++; $display("FAIL arb_idle_mem_en: got %b want 0", mem_en); end
  endtask

  task automatic test_clear;
    int clr_cycles = 0;
    int stalls = 0;
    int wr_leak = 0;
    int done_cnt = 0;
    int done_i = -1;
    logic done_clearing = 1'b1;
    logic stop = 1'b0;
    int bad = 0;
    @(negedge clk);
    clear_req = 1'b1; track = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    for (int i = 0; i < 3000 && !stop; i++) begin
      disp_rd_req = (i % 4 == 0); disp_rd_addr = 11'(i);
      #1;
      if (clearing) clr_cycles++;
      if (clearing && disp_rd_req) stalls++;
      if (clearing && wr_ready) wr_leak++;
      if (clear_done) begin
        done_cnt++;
        if (done_cnt == 1) begin done_i = i; done_clearing = clearing; track = 1'b0; end
      end
      if (done_i >= 0 && i >= done_i + 8) stop = 1'b1;
      @(negedge clk);
    end
    disp_rd_req = 1'b0; track = 1'b0;
    for (int k = 0; k < 4096; k++) begin
      if (k >= 2048) begin
        if (wcnt[k] != 1 || ram[k] !== 12'h000) bad++;
      end else if (wcnt[k] != 0) bad++;
    end
    n_cmp++; if (done_cnt != 1) begin n_bad++; $display("FAIL clr_done_pulses: got %0d want 1", done_cnt); end
    n_cmp++; if (done_i != 2731) begin n_bad++; $display("FAIL clr_done_cycle: got %0d want 2731", done_i); end
    n_cmp++; if (clr_cycles != 2731) begin n_bad++; $display("FAIL clr_busy_cycles: got %0d want 2731", clr_cycles); end
    n_cmp++; if (stalls != 683) begin n_bad++; $display("FAIL clr_stalls: got %0d want 683", stalls); end
    n_cmp++; if (wr_leak != 0) begin n_bad++; $display("FAIL clr_wr_ready: got %0d cycles want 0", wr_leak); end
    n_cmp++; if (done_clearing !== 1'b0) begin n_bad++; $display("FAIL clr_done_clearing: got %b want 0", done_clearing); end
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL clr_coverage: got %0d bad words want 0", bad); end
  endtask

  task automatic test_swap;
    @(negedge clk);
    swap_req = 1'b1;
    @(negedge clk);
    swap_req = 1'b0;
    #1;
    n_cmp++; if (swap_pending !== 1'b1) begin n_bad++; $display("FAIL swp_pending: got %b want 1", swap_pending); end
    n_cmp++; if (front_bank !== 1'b0) begin n_bad++; $display("FAIL swp_front_early: got %b want 0", front_bank); end
    repeat (9) @(negedge clk);
    frame_end = 1'b1;
    #1;
    n_cmp++; if (front_bank !== 1'b0) begin n_bad++; $display("FAIL swp_front_at_fe: got %b want 0", front_bank); end
    @(negedge clk);
    frame_end = 1'b0; disp_rd_req = 1'b1; disp_rd_addr = 11'd5;
    #1;
    n_cmp++; if (front_bank !== 1'b1) begin n_bad++; $display("FAIL swp_front: got %b want 1", front_bank); end
    n_cmp++; if (swap_pending !== 1'b0) begin n_bad++; $display("FAIL swp_pending_clr: got %b want 0", swap_pending); end
    n_cmp++; if (mem_addr !== 12'h805) begin n_bad++; $display("FAIL swp_rd_addr: got %h want 805", mem_addr); end
    @(negedge clk);
    disp_rd_req = 1'b0;
  endtask

  task automatic test_swap_coincident;
    @(negedge clk);
    swap_req = 1'b1; frame_end = 1'b1;
    @(negedge clk);
    swap_req = 1'b0; frame_end = 1'b0;
    #1;
    n_cmp++; if (front_bank !== 1'b1) begin n_bad++; $display("FAIL coin_front: got %b want 1", front_bank); end
    n_cmp++; if (swap_pending !== 1'b1) begin n_bad++; $display("FAIL coin_pending: got %b want 1", swap_pending); end
    repeat (3) @(negedge clk);
    frame_end = 1'b1;
    @(negedge clk);
    frame_end = 1'b0;
    #1;
    n_cmp++; if (front_bank !== 1'b0) begin n_bad++; $display("FAIL coin_front_next: got %b want 0", front_bank); end
    n_cmp++; if (swap_pending !== 1'b0) begin n_bad++; $display("FAIL coin_pending_next: got %b want 0", swap_pending); end
  endtask

  task automatic test_swap_blocked;
    logic seen = 1'b0;
    @(negedge clk);
    clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0; swap_req = 1'b1;
    #1;
    n_cmp++; if (clearing !== 1'b1) begin n_bad++; $display("FAIL blk_clearing: got %b want 1", clearing); end
    @(negedge clk);
    swap_req = 1'b0;
    #1;
    n_cmp++; if (swap_pending !== 1'b1) begin n_bad++; $display("FAIL blk_pending: got %b want 1", swap_pending); end
    @(negedge clk);
    frame_end = 1'b1;
    @(negedge clk);
    frame_end = 1'b0;
    #1;
    n_cmp++; if (front_bank !== 1'b0) begin n_bad++; $display("FAIL blk_front_held: got %b want 0", front_bank); end
    n_cmp++; if (swap_pending !== 1'b1) begin n_bad++; $display("FAIL blk_pending_held: got %b want 1", swap_pending); end
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clk);
      #1;
      if (clear_done) seen = 1'b1;
    end
    n_cmp++; if (seen !== 1'b1) begin n_bad++; $display("FAIL blk_clear_done_timeout: got %b want 1", seen); end
    @(negedge clk);
    frame_end = 1'b1;
    @(negedge clk);
    frame_end = 1'b0;
    #1;
    n_cmp++; if (front_bank !== 1'b1) begin n_bad++; $display("FAIL blk_front_after: got %b want 1", front_bank); end
    n_cmp++; if (swap_pending !== 1'b0) begin n_bad++; $display("FAIL blk_pending_after: got %b want 0", swap_pending); end
  endtask

  task automatic test_reset_mid_clear;
    @(negedge clk);
    clear_req = 1'b1; swap_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0; swap_req = 1'b0;
    #1;
    n_cmp++; if (clearing !== 1'b1) begin n_bad++; $display("FAIL mid_clearing: got %b want 1", clearing); end
    n_cmp++; if (swap_pending !== 1'b1) begin n_bad++; $display("FAIL mid_pending: got %b want 1", swap_pending); end
    repeat (300) @(negedge clk);
    rst = 1'b1; track2 = 1'b1;
    #1;
    n_cmp++; if (mem_en !== 1'b0) begin n_bad++; $display("FAIL mid_rst_mem_en: got %b want 0", mem_en); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++; if (clearing !== 1'b0) begin n_bad++; $display("FAIL mid_clearing_after: got %b want 0", clearing); end
    n_cmp++; if (swap_pending !== 1'b0) begin n_bad++; $display("FAIL mid_pending_after: got %b want 0", swap_pending); end
    n_cmp++; if (front_bank !== 1'b0) begin n_bad++; $display("FAIL mid_front_after: got %b want 0", front_bank); end
    repeat (5) @(negedge clk);
    track2 = 1'b0;
    #1;
    n_cmp++; if (post_writes != 0) begin n_bad++; $display("FAIL mid_stray_writes: got %0d want 0", post_writes); end
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    rst = 1'b1; ram_init = 1'b1; track = 1'b0; track2 = 1'b0;
    disp_rd_req = 1'b0; disp_rd_addr = '0;
    wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    swap_req = 1'b0; frame_end = 1'b0; clear_req = 1'b0;
    test_reset;
    test_read;
    test_arbitration;
    test_clear;
    test_swap;
    test_swap_coincident;
    test_swap_blocked;
    test_reset_mid_clear;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
